// File: rtl/atm_entry_pkg.sv
// ============================================================================
// Module : atm_entry_pkg
// Brief  : Shared key codes, entry-state encoding and operation codes for the
//          ATM keypad front-end. ATM_DISPLAY_MASK_EN adds the BCD helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package atm_entry_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam logic [3:0] KEY_LANG   = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC    = 3'd1,
        ST_PIN    = 3'd2,
        ST_OP     = 3'd3,
        ST_AMT    = 3'd4,
        ST_NEWPIN = 3'd5,
        ST_REQ    = 3'd6
    } entry_state_t;

    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHGPIN   = 3'd6;

`ifdef ATM_DISPLAY_MASK_EN
    // Shift-add-3 conversion; field values never exceed 9999.
    function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
        logic [29:0] sh;
        sh = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[14+4*d +: 4] >= 4'd5)
                    sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        return sh[29:14];
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/atm_idle_timer.sv
// ============================================================================
// Module : atm_idle_timer
// Brief  : Reloadable down-counter; expire pulses when the count runs out
//          while enabled and not being reloaded.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic enable,
    output logic expire
);

    localparam int                 c_cnt_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (reload) begin
            r_count <= c_reload;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    // A reload in the final cycle suppresses the expiry.
    assign expire = enable && !reload && (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/atm_keypad_entry.sv
// ============================================================================
// Module : atm_keypad_entry
// Brief  : Keypad entry FSM assembling ATM transactions onto a valid/ready
//          request port. ATM_DISPLAY_MASK_EN adds the display_bcd output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm_keypad_entry
    import atm_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_ACC        = 10,
    parameter int AMT_DIGITS     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [2:0]  req_operation,
    output logic [3:0]  req_acc_num,
    output logic [13:0] req_pin,
    output logic [13:0] req_amount,
    output logic [13:0] req_new_pin,
    output logic        req_language,
    output logic [2:0]  entry_state,
    output logic [2:0]  digit_count,
    output logic        entry_err,
    output logic        timeout
`ifdef ATM_DISPLAY_MASK_EN
    ,
    output logic [15:0] display_bcd
`endif
);

    localparam logic [13:0] c_max_acc   = 14'(MAX_ACC);
    localparam logic [2:0]  c_amt_limit = 3'(AMT_DIGITS);

    entry_state_t r_state;
    logic [13:0]  r_field;
    logic [2:0]   r_digit_count;
    logic [3:0]   r_acc_num;
    logic [13:0]  r_pin;
    logic [2:0]   r_op;
    logic         r_lang;

    logic [13:0]  w_field_next;
    logic [2:0]   w_limit;
    logic         w_timer_reload;
    logic         w_timer_enable;
    logic         w_expire;

    assign w_field_next   = (r_field * 14'd10) + {10'd0, key_code};
    assign w_timer_reload = key_valid || (r_state == ST_IDLE) || (r_state == ST_REQ);
    assign w_timer_enable = (r_state != ST_IDLE) && (r_state != ST_REQ);

    always_comb begin
        w_limit = 3'd0;
        case (r_state)
            ST_ACC:            w_limit = 3'd2;
            ST_PIN, ST_NEWPIN: w_limit = 3'd4;
            ST_AMT:            w_limit = c_amt_limit;
            default:           w_limit = 3'd0;
        endcase
    end

    atm_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .reload (w_timer_reload),
        .enable (w_timer_enable),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_field       <= '0;
            r_digit_count <= '0;
            r_acc_num     <= '0;
            r_pin         <= '0;
            r_op          <= '0;
            r_lang        <= 1'b0;
            entry_err     <= 1'b0;
            timeout       <= 1'b0;
            req_valid     <= 1'b0;
            req_operation <= '0;
            req_acc_num   <= '0;
            req_pin       <= '0;
            req_amount    <= '0;
            req_new_pin   <= '0;
            req_language  <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            timeout   <= 1'b0;
            if (w_expire) begin
                r_state       <= ST_IDLE;
                timeout       <= 1'b1;
                r_field       <= '0;
                r_digit_count <= '0;
                r_acc_num     <= '0;
                r_pin         <= '0;
                r_op          <= '0;
            end else if (r_state == ST_REQ) begin
                if (req_ready) begin
                    r_state       <= ST_IDLE;
                    req_valid     <= 1'b0;
                    req_operation <= '0;
                    req_acc_num   <= '0;
                    req_pin       <= '0;
                    req_amount    <= '0;
                    req_new_pin   <= '0;
                    req_language  <= 1'b0;
                    r_field       <= '0;
                    r_digit_count <= '0;
                    r_acc_num     <= '0;
                    r_pin         <= '0;
                    r_op          <= '0;
                end
            end else if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (r_state == ST_IDLE) begin
                        r_state       <= ST_ACC;
                        r_field       <= {10'd0, key_code};
                        r_digit_count <= 3'd1;
                    end else if (r_state == ST_OP) begin
                        r_field       <= {10'd0, key_code};
                        r_digit_count <= 3'd1;
                    end else if (r_digit_count < w_limit) begin
                        r_field       <= w_field_next;
                        r_digit_count <= r_digit_count + 3'd1;
                    end
                end else begin
                    case (key_code)
                        KEY_ENTER: begin
                            case (r_state)
                                ST_ACC: begin
                                    if ((r_field != '0) && (r_field <= c_max_acc)) begin
                                        r_acc_num <= r_field[3:0];
                                        r_state   <= ST_PIN;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                    r_field       <= '0;
                                    r_digit_count <= '0;
                                end
                                ST_PIN: begin
                                    if (r_digit_count == 3'd4) begin
                                        r_pin         <= r_field;
                                        r_state       <= ST_OP;
                                        r_field       <= '0;
                                        r_digit_count <= '0;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                end
                                ST_OP: begin
                                    if (r_field == {11'd0, OP_BALANCE}) begin
                                        r_state       <= ST_REQ;
                                        req_valid     <= 1'b1;
                                        req_operation <= OP_BALANCE;
                                        req_acc_num   <= r_acc_num;
                                        req_pin       <= r_pin;
                                        req_amount    <= '0;
                                        req_new_pin   <= '0;
                                        req_language  <= r_lang;
                                        r_field       <= '0;
                                        r_digit_count <= '0;
                                    end else if ((r_field == {11'd0, OP_WITHDRAW}) ||
                                                 (r_field == {11'd0, OP_DEPOSIT})) begin
                                        r_op          <= r_field[2:0];
                                        r_state       <= ST_AMT;
                                        r_field       <= '0;
                                        r_digit_count <= '0;
                                    end else if (r_field == {11'd0, OP_CHGPIN}) begin
                                        r_op          <= OP_CHGPIN;
                                        r_state       <= ST_NEWPIN;
                                        r_field       <= '0;
                                        r_digit_count <= '0;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                end
                                ST_AMT: begin
                                    if (r_field != '0) begin
                                        r_state       <= ST_REQ;
                                        req_valid     <= 1'b1;
                                        req_operation <= r_op;
                                        req_acc_num   <= r_acc_num;
                                        req_pin       <= r_pin;
                                        req_amount    <= r_field;
                                        req_new_pin   <= '0;
                                        req_language  <= r_lang;
                                        r_field       <= '0;
                                        r_digit_count <= '0;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                end
                                ST_NEWPIN: begin
                                    if ((r_digit_count == 3'd4) && (r_field != r_pin)) begin
                                        r_state       <= ST_REQ;
                                        req_valid     <= 1'b1;
                                        req_operation <= OP_CHGPIN;
                                        req_acc_num   <= r_acc_num;
                                        req_pin       <= r_pin;
                                        req_amount    <= '0;
                                        req_new_pin   <= r_field;
                                        req_language  <= r_lang;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                    r_field       <= '0;
                                    r_digit_count <= '0;
                                end
                                default: ;
                            endcase
                        end
                        KEY_CLEAR: begin
                            if (r_state != ST_IDLE) begin
                                r_field       <= '0;
                                r_digit_count <= '0;
                            end
                        end
                        KEY_CANCEL: begin
                            r_state       <= ST_IDLE;
                            r_field       <= '0;
                            r_digit_count <= '0;
                            r_acc_num     <= '0;
                            r_pin         <= '0;
                            r_op          <= '0;
                        end
                        KEY_LANG: r_lang <= ~r_lang;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign entry_state = r_state;
    assign digit_count = r_digit_count;

`ifdef ATM_DISPLAY_MASK_EN
    // Secret fields show one 0xF nibble per digit instead of the value.
    always_comb begin
        display_bcd = 16'd0;
        if ((r_state == ST_PIN) || (r_state == ST_NEWPIN)) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < r_digit_count)
                    display_bcd[4*i +: 4] = 4'hF;
            end
        end else begin
            display_bcd = bin_to_bcd(r_field);
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
- Upstream front-end of the ATM core. Collects keypad presses and assembles a complete transaction: account number, PIN, operation, amount or new PIN, and language.
- Presents the transaction on a valid/ready request port. Payload fields map 1:1 onto the core's operation/acc_num/pin/amount/newPin/language inputs.
- Owns field validation, cancel handling and the idle timeout, so the core only ever sees well-formed requests.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles without a key press before an in-progress entry is abandoned.
- MAX_ACC, 10, highest valid account number (valid range 1..MAX_ACC).
- AMT_DIGITS, 4, maximum digits accepted for the amount (AMT_DIGITS <= 4 keeps the value inside 14 bits).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD LANG; 0xE/0xF ignored.
- req_ready  in  1  ATM core accepts the request.
- req_valid  out  1  request payload is valid.
- req_operation  out  3  3 balance, 4 withdraw, 5 deposit, 6 change PIN.
- req_acc_num  out  4  account number.
- req_pin  out  14  PIN.
- req_amount  out  14  amount; 0 unless op 4/5.
- req_new_pin  out  14  new PIN; 0 unless op 6.
- req_language  out  1  language select.
- entry_state  out  3  current FSM state.
- digit_count  out  3  digits entered in the current field.
- entry_err  out  1  one-cycle pulse on a rejected ENTER.
- timeout  out  1  one-cycle pulse when an entry is abandoned.

Behaviour:
- Reset (rst==0 at posedge): all outputs and internal registers go to 0; entry_state = IDLE. Reset overrides everything, including an entry in progress or a pending REQ.
- State encoding: IDLE=0, ACC=1, PIN=2, OP=3, AMT=4, NEWPIN=5, REQ=6.
- Digit accumulation: field <= field*10 + digit, 14-bit, digit_count++.
  - Digit limits: ACC 2, PIN 4, NEWPIN 4, AMT AMT_DIGITS.
  - Digits beyond the limit are ignored and field and count are unchanged.
  - OP holds a single digit; a new digit replaces it.
- IDLE:
  - A digit enters ACC and is accumulated in the same cycle.
  - LANG toggles the language bit.
  - All other keys are ignored.
- ENTER, per state:
  - ACC: value in 1..MAX_ACC goes to PIN; otherwise entry_err and the field is cleared.
  - PIN: needs 4 digits, then goes to OP; otherwise entry_err.
  - OP: 3 goes to REQ; 4/5 go to AMT; 6 goes to NEWPIN; any other value gives entry_err.
  - AMT: value != 0 goes to REQ; otherwise entry_err.
  - NEWPIN: needs 4 digits and a value != PIN, then goes to REQ; otherwise entry_err and the field is cleared.
- Every state transition clears digit_count. Each newly entered field starts at 0.
- CLEAR: zeroes the current field and digit_count, and stays in the state.
- CANCEL: from any state except REQ, goes to IDLE and clears all fields. The language bit is kept.
- LANG: toggles the language bit in any state except REQ.
- REQ:
  - req_valid = 1 and the payload is held stable until req_ready is sampled 1.
  - Next cycle: IDLE, req_valid = 0, fields cleared.
  - All keys are ignored while in REQ.
- Latency: ENTER accepted in OP with op 3 gives req_valid on the next cycle.
- Timeout:
  - The counter reloads on every key_valid and in IDLE/REQ.
  - It counts in ACC..NEWPIN. After TIMEOUT_CYCLES idle cycles: IDLE, one timeout pulse, fields cleared.
  - A key arriving in the expiry cycle wins: the key is processed, the counter reloads and there is no timeout.
- req_* payload registers are zero whenever req_valid = 0.

Optional Feature:
- Macro: ATM_DISPLAY_MASK_EN.
- When defined, adds output display_bcd [15:0]: the current field as 4 BCD digits, right-aligned, unused nibbles 0. In PIN/NEWPIN each entered digit shows as 0xF. Reset value is 0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Decomposition:
- Package atm_entry_pkg holds:
  - key-code constants: KEY_ENTER, KEY_CLEAR, KEY_CANCEL, KEY_LANG;
  - state encoding constants;
  - op constants: OP_BALANCE=3, OP_WITHDRAW=4, OP_DEPOSIT=5, OP_CHGPIN=6.
- Sub-module atm_idle_timer: reloadable down-counter; inputs reload/enable; outputs a one-cycle expire pulse; parameterised by TIMEOUT_CYCLES.

Test Plan:
- Balance: keys 1,ENTER,1,2,3,4,ENTER,3,ENTER with req_ready=1 -> req_valid one cycle with op=3, acc=1, pin=1234, amount=0; then IDLE.
- Withdraw with backpressure: 2,ENTER,2,3,4,5,ENTER,4,ENTER,5,0,0,ENTER with req_ready held 0 for 5 cycles -> req_valid stays 1, payload stable (op=4, acc=2, pin=2345, amount=500); cleared the cycle after req_ready=1.
- Rejects:
  - ENTER after PIN digits 1,2,3 -> entry_err pulse, stays in PIN.
  - Account 1,1,ENTER -> entry_err, field cleared.
  - NEWPIN equal to PIN -> entry_err.
- Timeout: TIMEOUT_CYCLES=20; enter 1,ENTER,5 then idle 20 cycles -> timeout pulse, IDLE. A key in the expiry cycle -> no timeout.
- Cancel/clear/reset:
  - CANCEL in AMT -> IDLE, fields 0.
  - CLEAR in PIN -> digit_count 0.
  - rst=0 during REQ -> req_valid 0 next edge, entry_state 0.
